// File: rtl/clock_disp_pkg.sv
// Shared constants, slot-state encoding and BCD decode for the clock display path.
package clock_disp_pkg;

  // Active-high segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

  // Non-BCD codes render dark so a corrupted digit never shows a bogus glyph
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high 7-segment decoder.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with frame snapshot, per-slot
// anti-ghosting blank, optional leading-zero suppression and pin polarity select.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 12500,
  parameter int BLANK_CYC  = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int LZ_BLANK   = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] C1_in,
  input  logic [3:0] C2_in,
  input  logic [3:0] C3_in,
  input  logic [3:0] C4_in,
  input  logic [3:0] DP_in,
  input  logic       blank_in,
  output logic [6:0] SEG_out,
  output logic       DP_out,
  output logic [3:0] DIG_out,
  output logic       frame_start
);
  import clock_disp_pkg::*;

  localparam int              CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic            INV        = (ACTIVE_LOW != 0);
  localparam logic            LZ_EN      = (LZ_BLANK != 0);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic             w_wrap;
  logic             w_snap_en;
  logic [3:0]       r_snap [4];
  logic [3:0]       r_dp;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_dec;
  logic [6:0]       w_seg;
  logic [3:0]       w_lz;
  logic             w_suppress;
  logic             w_on;
  logic [3:0]       w_dig_oh;

  assign w_wrap    = (r_cnt == CNT_MAX);
  assign w_snap_en = (r_idx == 2'd0) && (r_cnt == '0);

  // Slot counter and digit index; the index steps once per completed slot
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Slot state register
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= ST_BLANK;
    else        r_state <= w_state_nxt;
  end

  // Slot state transitions: blank interval first, then drive until the slot ends
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (w_wrap)              w_state_nxt = ST_BLANK;
      default:                           w_state_nxt = ST_BLANK;
    endcase
  end

  // Frame snapshot at the start of slot 0 keeps all four digits coherent
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_snap      <= '{default: 4'd0};
      r_dp        <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_snap_en;
      if (w_snap_en) begin
        r_snap <= '{C1_in, C2_in, C3_in, C4_in};
        r_dp   <= DP_in;
      end
    end
  end

  // A digit is a leading zero when it and everything to its left are zero;
  // the rightmost digit always shows.
  assign w_lz[0] = (r_snap[0] == 4'd0);
  assign w_lz[1] = w_lz[0] && (r_snap[1] == 4'd0);
  assign w_lz[2] = w_lz[1] && (r_snap[2] == 4'd0);
  assign w_lz[3] = 1'b0;

  assign w_suppress = LZ_EN && w_lz[r_idx];
  assign w_digit    = r_snap[r_idx];

  seg7_decode u_decode (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  assign w_seg    = w_suppress ? SEG_OFF : w_seg_dec;
  assign w_on     = (r_state == ST_DRIVE) && !blank_in;
  assign w_dig_oh = 4'b0001 << r_idx;

  // Pin registers; polarity is applied only here, everything upstream is active-high
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      SEG_out <= {7{INV}};
      DIG_out <= {4{INV}};
      DP_out  <= INV;
    end else if (w_on) begin
      SEG_out <= w_seg ^ {7{INV}};
      DIG_out <= w_dig_oh ^ {4{INV}};
      DP_out  <= r_dp[r_idx] ^ INV;
    end else begin
      SEG_out <= {7{INV}};
      DIG_out <= {4{INV}};
      DP_out  <= INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (plain active-low, leading-zero
// active-low, plain active-high) share stimulus and are checked against a
// time-based reference model of the scan.
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] c1, c2, c3, c4, dpi;
  logic       blank;

  logic [6:0] seg_a, seg_l, seg_h;
  logic [3:0] dig_a, dig_l, dig_h;
  logic       dp_a, dp_l, dp_h;
  logic       fs_a, fs_l, fs_h;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1), .LZ_BLANK(0)) u_a (
    .CLK(clk), .RST_N(rst_n), .C1_in(c1), .C2_in(c2), .C3_in(c3), .C4_in(c4),
    .DP_in(dpi), .blank_in(blank), .SEG_out(seg_a), .DP_out(dp_a), .DIG_out(dig_a),
    .frame_start(fs_a));

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1), .LZ_BLANK(1)) u_l (
    .CLK(clk), .RST_N(rst_n), .C1_in(c1), .C2_in(c2), .C3_in(c3), .C4_in(c4),
    .DP_in(dpi), .blank_in(blank), .SEG_out(seg_l), .DP_out(dp_l), .DIG_out(dig_l),
    .frame_start(fs_l));

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(0), .LZ_BLANK(0)) u_h (
    .CLK(clk), .RST_N(rst_n), .C1_in(c1), .C2_in(c2), .C3_in(c3), .C4_in(c4),
    .DP_in(dpi), .blank_in(blank), .SEG_out(seg_h), .DP_out(dp_h), .DIG_out(dig_h),
    .frame_start(fs_h));

  logic [12:0] obs [3];
  always_comb begin
    obs[0] = {fs_a, dp_a, dig_a, seg_a};
    obs[1] = {fs_l, dp_l, dig_l, seg_l};
    obs[2] = {fs_h, dp_h, dig_h, seg_h};
  end

  // Reference model state: t = cycles since reset release
  int          t;
  logic [3:0]  m_snap [4];
  logic [3:0]  m_dp;
  logic [12:0] exp_v [3];
  logic [6:0]  tbl [16];

  int total = 0;
  int bad   = 0;

  // Advance one clock: predict the pins for the coming edge, then step past it
  task automatic tick();
    logic [3:0] cin [4];
    int p, i;
    logic drive, sup, dpo, fs;
    logic [6:0] s, sl;
    logic [3:0] d;
    cin = '{c1, c2, c3, c4};
    if (!rst_n) begin
      t = 0;
      m_snap = '{default: 4'd0};
      m_dp = 4'd0;
      exp_v[0] = 13'h0FFF;
      exp_v[1] = 13'h0FFF;
      exp_v[2] = 13'h0000;
    end else begin
      p = t % SD;
      i = (t / SD) % 4;
      drive = (p >= BC) && !blank;
      d = drive ? 4'(1 << i) : 4'b0000;
      s = drive ? tbl[m_snap[i]] : 7'h00;
      sup = (i < 3);
      for (int k = 0; k < 3; k++) if (k <= i && m_snap[k] != 4'd0) sup = 1'b0;
      sl = sup ? 7'h00 : s;
      dpo = drive & m_dp[i];
      fs = ((t % (4 * SD)) == 0);
      exp_v[0] = {fs, ~dpo, ~d, ~s};
      exp_v[1] = {fs, ~dpo, ~d, ~sl};
      exp_v[2] = {fs, dpo, d, s};
      if (fs) begin
        m_snap = cin;
        m_dp = dpi;
      end
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first_fs;
    rst_n = 1'b0; blank = 1'b0;
    c1 = 4'd1; c2 = 4'd2; c3 = 4'd3; c4 = 4'd4; dpi = 4'b0000;
    repeat (3) begin
      tick();
      total++;
      if ({seg_a, dig_a, dp_a, fs_a} !== 13'h1FFE) begin
        bad++;
        $display("FAIL reset_low got=%h want=1ffe", {seg_a, dig_a, dp_a, fs_a});
      end
      total++;
      if ({seg_h, dig_h, dp_h, fs_h} !== 13'h0000) begin
        bad++;
        $display("FAIL reset_high got=%h want=0000", {seg_h, dig_h, dp_h, fs_h});
      end
    end
    rst_n = 1'b1;
    first_fs = 0;
    for (int j = 1; j <= 70; j++) begin
      tick();
      if (fs_a && first_fs == 0) first_fs = j;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL reset_scan inst=%0d t=%0d got=%h want=%h", k, t, obs[k], exp_v[k]);
        end
      end
      if (j == 3 || j == 35) begin
        total++;
        if (dig_a !== 4'b1110 || seg_a !== 7'h79) begin
          bad++;
          $display("FAIL first_digit j=%0d got dig=%b seg=%h want dig=1110 seg=79", j, dig_a, seg_a);
        end
      end
    end
    total++;
    if (first_fs != 1) begin
      bad++;
      $display("FAIL frame_start_first got=%0d want=1", first_fs);
    end
  endtask

  task automatic test_tear();
    int n;
    n = 0;
    while (!(((t % 32) / 8) == 1 && (t % 8) >= 3) && n < 64) begin tick(); n++; end
    total++;
    if (n >= 64) begin bad++; $display("FAIL tear_wait got=%0d want<64", n); end
    c2 = 4'd9;
    tick();
    total++;
    if (dig_a !== 4'b1101 || seg_a !== 7'h24) begin
      bad++;
      $display("FAIL tear_hold got dig=%b seg=%h want dig=1101 seg=24", dig_a, seg_a);
    end
    for (int j = 0; j < 60; j++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL tear inst=%0d t=%0d got=%h want=%h", k, t, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_lz();
    for (int r = 0; r < 2; r++) begin
      c1 = 4'd0; c2 = 4'd0; c3 = (r == 0) ? 4'd5 : 4'd0; c4 = 4'd0;
      for (int j = 0; j < 70; j++) begin
        tick();
        for (int k = 0; k < 3; k++) begin
          total++;
          if (obs[k] !== exp_v[k]) begin
            bad++;
            $display("FAIL lz%0d inst=%0d t=%0d got=%h want=%h", r, k, t, obs[k], exp_v[k]);
          end
        end
        if ((t - 1) % 32 == 4 && j > 40) begin
          total++;
          if (dig_l !== 4'b1110 || seg_l !== 7'h7F) begin
            bad++;
            $display("FAIL lz_slot0 got dig=%b seg=%h want dig=1110 seg=7f", dig_l, seg_l);
          end
        end
      end
    end
  endtask

  task automatic test_invalid_dp();
    c1 = 4'd7; c2 = 4'd8; c3 = 4'hC; c4 = 4'd0; dpi = 4'b0100;
    for (int j = 0; j < 70; j++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL invalid_dp inst=%0d t=%0d got=%h want=%h", k, t, obs[k], exp_v[k]);
        end
      end
      if ((t - 1) % 32 == 20 && j > 40) begin
        total++;
        if (dig_a !== 4'b1011 || seg_a !== 7'h7F || dp_a !== 1'b0) begin
          bad++;
          $display("FAIL invalid_slot2 got dig=%b seg=%h dp=%b want 1011/7f/0", dig_a, seg_a, dp_a);
        end
      end
    end
    dpi = 4'b0000;
  endtask

  task automatic test_blank();
    int n;
    n = 0;
    while ((t % 32) != 13 && n < 64) begin tick(); n++; end
    total++;
    if (n >= 64) begin bad++; $display("FAIL blank_wait got=%0d want<64", n); end
    blank = 1'b1;
    repeat (10) begin
      tick();
      total++;
      if (dig_a !== 4'b1111 || dig_h !== 4'b0000) begin
        bad++;
        $display("FAIL blank_dark got dig_a=%b dig_h=%b want 1111/0000", dig_a, dig_h);
      end
    end
    blank = 1'b0;
    for (int j = 0; j < 50; j++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL blank_resume inst=%0d t=%0d got=%h want=%h", k, t, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        c1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        c2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        c3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        c4 = 4'($urandom_range(0, 15));
        dpi = 4'($urandom_range(0, 15));
      end
      blank = ($urandom_range(0, 7) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL random inst=%0d t=%0d got=%h want=%h", k, t, obs[k], exp_v[k]);
        end
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n;
    c1 = 4'd3; c2 = 4'd1; c3 = 4'd6; c4 = 4'd2; dpi = 4'b1001;
    n = 0;
    while ((t % 32) != 20 && n < 64) begin tick(); n++; end
    total++;
    if (n >= 64) begin bad++; $display("FAIL midrst_wait got=%0d want<64", n); end
    rst_n = 1'b0;
    repeat (2) begin
      tick();
      total++;
      if ({seg_a, dig_a, dp_a, fs_a} !== 13'h1FFE) begin
        bad++;
        $display("FAIL midrst_low got=%h want=1ffe", {seg_a, dig_a, dp_a, fs_a});
      end
      total++;
      if ({seg_h, dig_h, dp_h, fs_h} !== 13'h0000) begin
        bad++;
        $display("FAIL midrst_high got=%h want=0000", {seg_h, dig_h, dp_h, fs_h});
      end
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 70; j++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL midrst_scan inst=%0d t=%0d got=%h want=%h", k, t, obs[k], exp_v[k]);
        end
      end
      if (j == 3) begin
        total++;
        if (dig_h !== 4'b0001 || seg_h !== 7'h4F || dp_h !== 1'b1) begin
          bad++;
          $display("FAIL midrst_restart got dig=%b seg=%h dp=%b want 0001/4f/1", dig_h, seg_h, dp_h);
        end
      end
    end
  endtask

  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    t = 0;
    m_snap = '{default: 4'd0};
    m_dp = 4'd0;
    exp_v = '{default: 13'h0};
    test_reset();
    test_tear();
    test_lz();
    test_invalid_dp();
    test_blank();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
